fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR controller: accepts one unsigned sample per handshake, shifts it into a tap delay line and sequences a single shared 8×8 multiplier-accumulator over all taps, one tap per cycle. It then presents the scaled, saturated result on a valid/ready output. It sits between the input-switch sampler and the output driver of the filter tile. It replaces the fully parallel tap array, trading throughput for one multiplier.

---
 rtl/fir_ctrl_pkg.sv | 26 ++
 rtl/fir_coef_bank.sv | 49 ++++
 rtl/fir_mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
// Shared definitions for the time-multiplexed FIR controller:
//   - controller state encoding (IDLE=0, MAC=1, OUT=2)
//   - reset-default coefficient set (unity gain, h[0] first)
//   - accumulator width helper used to size AW
package fir_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int DEF_TAPS = 4;
  localparam logic [7:0] COEF_DEFAULT [DEF_TAPS] = '{8'h3C, 8'h44, 8'h44, 8'h3C};

  // Enough headroom for TAPS full-scale products to be summed without wrap.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Default coefficient for a tap index; the table repeats for banks wider
  // than the default set.
  function automatic logic [7:0] coef_default(input int idx);
    return COEF_DEFAULT[idx % DEF_TAPS];
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank
// TAPS x CW coefficient register file with one write port and a
// combinational read port indexed by tap.
// Build option FIR_COEF_WRITE_EN:
//   defined   - coefficients live in flops, loaded with the defaults on reset
//               and overwritten through the write port.
//   undefined - write port is ignored; the read port returns the constant
//               defaults and no coefficient storage exists.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   we/waddr/wdata  write strobe, tap index, coefficient value (already qualified)
//   rd_idx          tap index to read
//   rd_data         coefficient for rd_idx
module fir_coef_bank
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS = 4,
  parameter int CW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(TAPS)-1:0]  waddr,
  input  logic [CW-1:0]            wdata,
  input  logic [$clog2(TAPS)-1:0]  rd_idx,
  output logic [CW-1:0]            rd_data
);

`ifdef FIR_COEF_WRITE_EN
  logic [CW-1:0] h [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) h[i] <= CW'(coef_default(i));
    end else if (we) begin
      h[waddr] <= wdata;
    end
  end

  assign rd_data = h[rd_idx];
`else
  // Write port is kept for pin compatibility only.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, we, waddr, wdata};

  assign rd_data = CW'(coef_default(int'(rd_idx)));
`endif

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR: accepts one unsigned sample per handshake, shifts it
// into a TAPS-deep delay line, then runs one shared multiplier-accumulator
// over the taps, one tap per cycle. The result (acc bits DW+CW-1:CW,
// saturated to all-ones on overflow) is presented on a valid/ready port.
// Build option FIR_COEF_WRITE_EN enables the coefficient write port
// (see fir_coef_bank).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ena                        synchronous enable (low: everything holds)
//   flush                      synchronous clear of data path and output
//   s_valid/s_ready/s_data     sample input handshake
//   m_valid/m_ready/m_data     result output handshake
//   coef_we/coef_addr/coef_data coefficient write (only taken in IDLE)
//   busy                       high while in MAC or OUT
module fir_mac_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int AW   = acc_width(DW, CW, TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DW-1:0]            m_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     busy
);

  localparam int KW = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam int GW = AW - DW - CW;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [DW-1:0]    x [TAPS];
  logic [AW-1:0]    acc;
  logic [CW-1:0]    h_k;
  logic [DW+CW-1:0] prod;
  logic [AW-1:0]    acc_next;
  logic             coef_wr;

  // Scale to the output width, clamping to all-ones if any guard bit is set.
  function automatic logic [DW-1:0] sat_scale(input logic [GW-1:0] guard,
                                               input logic [DW-1:0] scaled);
    return (guard != '0) ? '1 : scaled;
  endfunction

  // Writes only land while idle; a flush or a held enable drops them.
  assign coef_wr = coef_we && ena && !flush && (state == ST_IDLE);

  fir_coef_bank #(
    .TAPS (TAPS),
    .CW   (CW)
  ) u_coef_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (coef_wr),
    .waddr   (coef_addr),
    .wdata   (coef_data),
    .rd_idx  (k),
    .rd_data (h_k)
  );

  // MAC stage: one tap product per cycle, zero-extended into the accumulator.
  assign prod     = {{CW{1'b0}}, x[k]} * {{DW{1'b0}}, h_k};
  assign acc_next = acc + {{GW{1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      k       <= '0;
      acc     <= '0;
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
    end else if (flush) begin
      state   <= ST_IDLE;
      k       <= '0;
      acc     <= '0;
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      s_ready <= 1'b1;
      busy    <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            x[0] <= s_data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc     <= '0;
            k       <= '0;
            state   <= ST_MAC;
            s_ready <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_MAC: begin
          acc <= acc_next;
          k   <= k + KW'(1);
          // The last tap's product is folded in on the same edge the
          // result is loaded, so the output sees the complete sum.
          if (k == K_LAST) begin
            m_data  <= sat_scale(acc_next[AW-1:DW+CW], acc_next[DW+CW-1:CW]);
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ST_IDLE;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          m_valid <= 1'b0;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
// Directed and randomized stimulus for fir_mac_sequencer, checked against a
// plain-arithmetic FIR model (sum of h[i]*x[i], scaled by 1/256, clamped).
module tb_fir_mac_sequencer;

  localparam int TAPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       coef_we = 1'b0;
  logic [1:0] coef_addr = 2'd0;
  logic [7:0] coef_data = 8'h00;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [7:0] last_y = 8'h00;

  int h_m [TAPS];
  int hist [TAPS];

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    h_m[0] = 'h3C; h_m[1] = 'h44; h_m[2] = 'h44; h_m[3] = 'h3C;
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input int s);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endfunction

  function automatic int model_y();
    int sum;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += h_m[i] * hist[i];
    if (sum >= 65536) return 255;
    return sum / 256;
  endfunction

  task automatic wr_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = 8'(d);
    @(negedge clk);
    coef_we = 1'b0;
`ifdef FIR_COEF_WRITE_EN
    h_m[a] = d;
`endif
  endtask

  // One full sample transaction starting at a negedge; returns at the negedge
  // after the result handshake.
  task automatic send(input int s, input int stall, input bit wr_busy,
                      input bit wr_now, input int wa, input int wd);
    int n;
    int exp;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    chk("s_ready_idle", s_ready, 1);
    t_acc = cyc;
    s_valid = 1'b1; s_data = 8'(s); m_ready = (stall == 0);
    if (wr_now) begin
      coef_we = 1'b1; coef_addr = 2'(wa); coef_data = 8'(wd);
`ifdef FIR_COEF_WRITE_EN
      h_m[wa] = wd;
`endif
    end
    model_push(s);
    exp = model_y();
    @(negedge clk);
    s_valid = 1'b0; coef_we = 1'b0;
    chk("busy_mac", busy, 1);
    chk("s_ready_mac", s_ready, 0);
    n = 1;
    if (wr_busy) begin
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'hFF;
      @(negedge clk);
      n++;
      coef_we = 1'b0;
    end
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, TAPS + 1);
    chk("m_data", m_data, exp);
    last_y = m_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_m_valid", m_valid, 1);
      chk("stall_m_data", m_data, exp);
      chk("stall_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("m_valid_clr", m_valid, 0);
    chk("s_ready_back", s_ready, 1);
  endtask

  initial begin
    logic [7:0] imp_exp [5];
    int t1;
    imp_exp = '{8'h1E, 8'h22, 8'h22, 8'h1E, 8'h00};
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1 chk("s_ready_pre_edge", s_ready, 0);
    @(negedge clk);
    chk("s_ready_first_edge", s_ready, 1);

    // Impulse response
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 'h80 : 0, 0, 0, 0, 0, 0);
      chk("impulse", last_y, imp_exp[i]);
    end

    // Constant inputs, and back-to-back period
    for (int i = 0; i < 5; i++) send('hFF, 0, 0, 0, 0, 0);
    chk("const_ff", last_y, 8'hFF);
    for (int i = 0; i < 4; i++) send('h80, 0, 0, 0, 0, 0);
    t1 = t_acc;
    send('h80, 0, 0, 0, 0, 0);
    chk("period", t_acc - t1, 6);
    chk("const_80", last_y, 8'h80);

    // Downstream back-pressure for 10 cycles
    send('h80, 10, 0, 0, 0, 0);

    // Enable low: no accept despite s_valid
    ena = 1'b0; s_valid = 1'b1; s_data = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("ena_hold_ready", s_ready, 1);
      chk("ena_hold_busy", busy, 0);
    end
    s_valid = 1'b0; ena = 1'b1;
    @(negedge clk);
    chk("ena_no_accept", busy, 0);

    // Flush mid-MAC
    s_valid = 1'b1; s_data = 8'h99;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre_flush_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    chk("flush_busy", busy, 0);
    chk("flush_s_ready", s_ready, 1);
    repeat (8) begin
      chk("flush_no_result", m_valid, 0);
      @(negedge clk);
    end
    send('h40, 0, 0, 0, 0, 0);
    chk("post_flush", last_y, 8'h0F);

    // Coefficient write while busy must not land
    send('h80, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send('h80, 0, 0, 0, 0, 0);

    // Write and accept in the same idle cycle
    send('h80, 0, 0, 1, 0, 'h00);
    send('h80, 0, 0, 0, 0, 0);

    // All-ones coefficients saturate
    for (int i = 0; i < TAPS; i++) wr_coef(i, 'hFF);
    for (int i = 0; i < 4; i++) send('hFF, 0, 0, 0, 0, 0);
    chk("saturate", last_y, 8'hFF);

    // Randomized traffic
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(3) == 0) wr_coef(int'($urandom_range(3)), int'($urandom_range(255)));
      send(int'($urandom_range(255)), int'($urandom_range(3)), 0,
           ($urandom_range(4) == 0), int'($urandom_range(3)), int'($urandom_range(255)));
    end

    // Asynchronous reset mid-MAC after custom coefficients
    wr_coef(0, 'hA5);
    wr_coef(3, 'h11);
    send('hFF, 0, 0, 0, 0, 0);
    s_valid = 1'b1; s_data = 8'h55;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_m_data", m_data, 0);
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_s_ready", s_ready, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1 chk("rel_s_ready", s_ready, 0);
    @(negedge clk);
    chk("rel_s_ready_edge", s_ready, 1);
    send('h80, 0, 0, 0, 0, 0);
    chk("default_coef_restored", last_y, 8'h1E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
